// File: rtl/beam_thresh_scheduler.sv
// Per-beam threshold shadow store and load sequencer for the L1 beamformers.
// Dirty beams are streamed onto the shared thresh bus, then one update strobe.
module beam_thresh_scheduler #(
  parameter int NBEAMS         = 46,
  parameter int THRESH_BITS    = 18,
  parameter int DEFAULT_THRESH = 20000,
  parameter int UPDATE_GAP     = 1,
  parameter int AW             = $clog2(NBEAMS)
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   wr_valid_i,
  output logic                   wr_ready_o,
  input  logic [AW-1:0]          wr_addr_i,
  input  logic [THRESH_BITS-1:0] wr_data_i,
  output logic                   wr_err_o,
  input  logic                   commit_i,
  input  logic                   commit_all_i,
  input  logic [AW-1:0]          rd_addr_i,
  output logic [THRESH_BITS-1:0] rd_data_o,
  output logic                   busy_o,
  output logic [THRESH_BITS-1:0] thresh_o,
  output logic [NBEAMS-1:0]      thresh_ce_o,
  output logic                   update_o
);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    GAP,
    UPD
  } state_t;

  localparam logic [AW:0] NB_W =
    (AW+1)'(NBEAMS);
  localparam logic [AW-1:0] LAST =
    AW'(NBEAMS-1);
  localparam logic [2:0] GAP_LAST =
    3'(UPDATE_GAP-1);
  localparam logic [THRESH_BITS-1:0] DEF =
    THRESH_BITS'(DEFAULT_THRESH);

  state_t state_q, state_d;

  logic [AW-1:0]          idx_q, idx_d;
  logic [2:0]             gap_q, gap_d;
  logic                   pending_q, pending_d;
  logic [NBEAMS-1:0]      dirty_q, dirty_d;
  logic [THRESH_BITS-1:0] shadow_q [NBEAMS];
  logic [THRESH_BITS-1:0] shadow_d [NBEAMS];
  logic [THRESH_BITS-1:0] thresh_q, thresh_d;
  logic [NBEAMS-1:0]      ce_q, ce_d;
  logic                   upd_q, upd_d;
  logic                   err_q, err_d;
  logic [THRESH_BITS-1:0] rd_q, rd_d;
  logic                   busy_q, busy_d;

  logic wr_fire;
  logic wr_in;
  logic rd_in;

  // busy_q low already implies IDLE with nothing pending
  assign wr_ready_o = ~busy_q;
  assign wr_fire    = wr_valid_i & ~busy_q;
  assign wr_in      = {1'b0, wr_addr_i} < NB_W;
  assign rd_in      = {1'b0, rd_addr_i} < NB_W;

  assign wr_err_o    = err_q;
  assign rd_data_o   = rd_q;
  assign busy_o      = busy_q;
  assign thresh_o    = thresh_q;
  assign thresh_ce_o = ce_q;
  assign update_o    = upd_q;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    gap_d     = gap_q;
    pending_d = pending_q;
    dirty_d   = dirty_q;
    shadow_d  = shadow_q;
    thresh_d  = thresh_q;
    ce_d      = '0;
    upd_d     = 1'b0;
    err_d     = 1'b0;
    rd_d      = '0;

    if (rd_in) begin
      rd_d = shadow_q[rd_addr_i];
    end

    if (wr_fire) begin
      if (wr_in) begin
        shadow_d[wr_addr_i] = wr_data_i;
        dirty_d[wr_addr_i]  = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (pending_q) begin
          state_d   = SCAN;
          idx_d     = '0;
          pending_d = 1'b0;
        end
      end
      SCAN: begin
        if (dirty_q[idx_q]) begin
          thresh_d       = shadow_q[idx_q];
          ce_d[idx_q]    = 1'b1;
          dirty_d[idx_q] = 1'b0;
        end
        if (idx_q == LAST) begin
          state_d = (UPDATE_GAP > 0) ? GAP : UPD;
          gap_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = UPD;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      UPD: begin
        upd_d = 1'b1;
        idx_d = '0;
        if (pending_q) begin
          state_d   = SCAN;
          pending_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // commit_all overrides the scan's clear so scanned beams reload
    if (commit_i | commit_all_i) begin
      pending_d = 1'b1;
    end
    if (commit_all_i) begin
      dirty_d = '1;
    end

    busy_d = (state_d != IDLE) | pending_d | upd_d;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      gap_q     <= '0;
      pending_q <= 1'b1;
      dirty_q   <= '1;
      for (int i = 0; i < NBEAMS; i++) begin
        shadow_q[i] <= DEF;
      end
      thresh_q  <= '0;
      ce_q      <= '0;
      upd_q     <= 1'b0;
      err_q     <= 1'b0;
      rd_q      <= '0;
      busy_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      gap_q     <= gap_d;
      pending_q <= pending_d;
      dirty_q   <= dirty_d;
      shadow_q  <= shadow_d;
      thresh_q  <= thresh_d;
      ce_q      <= ce_d;
      upd_q     <= upd_d;
      err_q     <= err_d;
      rd_q      <= rd_d;
      busy_q    <= busy_d;
    end
  end

endmodule

// File: doc/beam_thresh_scheduler.md
Name: beam_thresh_scheduler

Overview:
- Owns the per-beam trigger thresholds for the L1 beamformer array.
- Holds a shadow copy of every beam's 18-bit threshold, written by the register/servo side. On commit it walks all beams and loads each modified threshold onto the beamformers' shared `thresh`/`thresh_ce` bus, one beam per clock. It then issues a single `update` strobe so all new thresholds take effect together.
- Sits between the control register space and the beam alignment/beamformer block.

Parameters:
- NBEAMS, 46, number of beams served; also the width of `thresh_ce_o`.
- THRESH_BITS, 18, threshold width.
- DEFAULT_THRESH, 20000, shadow value loaded at reset.
- UPDATE_GAP, 1, minimum idle cycles between the last `thresh_ce_o` cycle and `update_o` (range 0..7).
- AW, $clog2(NBEAMS), beam address width.

Ports:
- clk_i  in  1  system clock
- rst_n_i  in  1  synchronous active-low reset
- wr_valid_i  in  1  threshold write request
- wr_ready_o  out  1  write accepted when high together with `wr_valid_i`
- wr_addr_i  in  AW  beam index to write
- wr_data_i  in  THRESH_BITS  new threshold
- wr_err_o  out  1  one-cycle pulse: accepted write had `addr >= NBEAMS`
- commit_i  in  1  load all dirty beams, then update
- commit_all_i  in  1  mark every beam dirty, then behave as `commit_i`
- rd_addr_i  in  AW  shadow readback address
- rd_data_o  out  THRESH_BITS  `shadow[rd_addr_i]`, registered, 1-cycle latency; 0 for out-of-range addresses
- busy_o  out  1  a load sequence is running or pending
- thresh_o  out  THRESH_BITS  threshold bus to beamformers
- thresh_ce_o  out  NBEAMS  per-beam load enable, at most one bit high
- update_o  out  1  one-cycle strobe: apply loaded thresholds

Behaviour:
Reset (`rst_n_i` low at a clock edge):
- Shadow[all] = DEFAULT_THRESH, dirty[all] = 1, pending = 1, state = IDLE.
- Output reset values: `thresh_o` = 0, `thresh_ce_o` = 0, `update_o` = 0, `wr_err_o` = 0, `rd_data_o` = 0, `busy_o` = 1, `wr_ready_o` = 0.
- After release, a full default load runs automatically.
- Reset mid-sequence aborts it immediately: no further `ce` or `update` pulses, and the state above is restored.

States: IDLE, SCAN, GAP, UPD.
- IDLE: `wr_ready_o` = !pending. If pending → SCAN with idx = 0 and pending cleared.
- SCAN: one beam index per cycle. If dirty[idx]:
  - next cycle `thresh_o` = shadow[idx] and `thresh_ce_o` = one-hot(idx);
  - dirty[idx] is cleared.
  - Otherwise `thresh_ce_o` = 0 next cycle; `thresh_o` holds its last value.
  - When idx = NBEAMS-1: → GAP if UPDATE_GAP > 0, else → UPD.
- GAP: count UPDATE_GAP cycles, then → UPD.
- UPD: `update_o` = 1 for exactly the next cycle. Then → SCAN (idx = 0) if pending, else → IDLE.

Timing:
- Commit sampled at edge 0 in IDLE: SCAN occupies cycles 1..NBEAMS.
- `thresh_ce_o[k]` is high in cycle k+2 (if dirty).
- `update_o` is high in cycle NBEAMS+2+UPDATE_GAP.
- The sequence length is fixed whatever the dirty count. With zero dirty beams, `update_o` still pulses.
- `busy_o` is registered: high from cycle 1 (or while pending) through the `update_o` cycle; low the cycle after if nothing is pending.

Writes:
- Accepted only when `wr_valid_i` && `wr_ready_o` (IDLE, no pending).
- In-range write: shadow[addr] = data, dirty[addr] = 1.
- Out-of-range write: dropped, `wr_err_o` pulses the next cycle.
- Writes are never accepted while busy; the writer stalls.

Commits:
- `commit_i` or `commit_all_i` in any state sets pending. A commit during SCAN/GAP/UPD runs a second full sequence back-to-back after the current `update_o`.
- A write and a commit accepted in the same IDLE cycle: the write is included in the triggered sequence.
- `commit_all_i` sets all dirty bits at the cycle it is sampled; beams already scanned in the current sequence are reloaded in the pending one.

Readback:
- `rd_data_o` reflects shadow contents, including uncommitted writes.

Test Plan:
- Reset release, NBEAMS=46, UPDATE_GAP=1:
  - `busy_o` = 1 out of reset.
  - `thresh_ce_o` walks bits 0..45 in 46 consecutive cycles, each with `thresh_o` = 20000.
  - One idle cycle, then a single `update_o` pulse, then `busy_o` = 0 and `wr_ready_o` = 1.
- Write beam 7 = 0x12345 and beam 30 = 0x00FFF, then commit at cycle 0:
  - `thresh_ce_o` = bit7 with 0x12345 at cycle 9.
  - `thresh_ce_o` = bit30 with 0x00FFF at cycle 32.
  - No other `ce`; `update_o` at cycle 49.
- Commit with no dirty beams → no `ce` pulses; `update_o` at cycle 49; `busy_o` low at cycle 50.
- `commit_i` pulsed during SCAN of a sequence → `wr_ready_o` stays 0. A second sequence starts the cycle after the first `update_o`, and exactly two `update_o` pulses occur in total.
- Write to addr 50 → `wr_err_o` pulses once, shadow is unchanged (readback of addr 50 = 0), and no dirty bit is set.
- Write beam 3 = 5, commit, assert reset at cycle 6 → no further `ce` or `update_o`. After release, a full reload with 20000 runs on all beams, and readback of beam 3 = 20000.
